segment_sequencer: RTL and testbench

Controller that schedules characters into the 7-segment animator. It holds a short message in a small register file and presents one character at a time on the `char_out`/`char_available` pair the animator consumes. Each character dwells for a programmed number of 60 Hz ticks, optionally followed by a blank gap. The block runs entirely in the 60 Hz domain and supports one-shot or looped playback, hold (pause) and abort.

---
 rtl/segment_pkg.sv | 22 ++
 rtl/segment_sequencer_if.sv | 34 +++
 rtl/segment_sequencer_dwell_timer.sv | 36 +++
 rtl/segment_sequencer.sv | 135 +++++++++++++
 tb/tb_segment_sequencer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/segment_pkg.sv
// rtl/segment_pkg.sv - shared types for the 7-segment sequencer and animator
package segment_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SHOW = 2'd1,
      S_GAP  = 2'd2
   } seq_state_e;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h00;

   // Counter width: wide enough for the larger of DWELL-1 and GAP-1, never below 1 bit.
   function automatic int cnt_width(input int dwell, input int gap);
      int m;
      m = (dwell > gap) ? dwell : gap;
      if (m < 2) m = 2;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/segment_sequencer_if.sv
// rtl/segment_sequencer_if.sv - host and animator facing signal bundle of the segment sequencer
interface segment_sequencer_if #(
   parameter int MSG_DEPTH = 8
);
   import segment_pkg::*;

   localparam int IDX_W = $clog2(MSG_DEPTH);

   logic             enable;
   logic             wr_en;
   logic [IDX_W-1:0] wr_addr;
   seg_t             wr_data;
   logic [IDX_W:0]   msg_len;
   logic             start;
   logic             stop;
   logic             loop;
   logic             hold;
   seg_t             char_out;
   logic             char_available;
   logic [IDX_W-1:0] char_index;
   logic             busy;
   logic             done;

   modport master (
      output enable, wr_en, wr_addr, wr_data, msg_len, start, stop, loop, hold,
      input  char_out, char_available, char_index, busy, done
   );

   modport slave (
      input  enable, wr_en, wr_addr, wr_data, msg_len, start, stop, loop, hold,
      output char_out, char_available, char_index, busy, done
   );

endinterface

// File: rtl/segment_sequencer_dwell_timer.sv
// rtl/segment_sequencer_dwell_timer.sv - loadable dwell/gap down-counter with hold and zero flag
module dwell_timer #(
   parameter int W = 6
) (
   input  logic         clk60,
   input  logic         reset,
   input  logic         enable,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         hold,
   output logic         zero
);

   logic [W-1:0] cnt_q, cnt_d;

   // Stops at zero rather than wrapping; the FSM reloads it on every transition.
   always_comb begin
      cnt_d = cnt_q;
      if (enable) begin
         if (load)
            cnt_d = load_val;
         else if (!hold && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk60 or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/segment_sequencer.sv
// rtl/segment_sequencer.sv - plays a short stored message into the 7-segment animator, one character per dwell
module segment_sequencer
   import segment_pkg::*;
#(
   parameter int MSG_DEPTH = 8,
   parameter int DWELL     = 48,
   parameter int GAP       = 8
) (
   input  logic                clk60,
   input  logic                reset,
   segment_sequencer_if.slave  bus
);

   localparam int                IDX_W    = $clog2(MSG_DEPTH);
   localparam int                CNT_W    = cnt_width(DWELL, GAP);
   localparam logic [IDX_W:0]    DEPTH_L  = (IDX_W+1)'(MSG_DEPTH);
   localparam logic [CNT_W-1:0]  DWELL_LD = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'((GAP > 0) ? GAP - 1 : 0);

   seq_state_e       state_q, state_d;
   seg_t             mem_q [MSG_DEPTH];
   seg_t             char_q, char_d;
   logic             avail_q, avail_d;
   logic             done_q, done_d;
   logic [IDX_W-1:0] index_q, index_d, next_idx;
   logic [IDX_W:0]   len_q, len_d;
   logic             mem_we;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_zero;

   dwell_timer #(.W(CNT_W)) u_timer (
      .clk60    (clk60),
      .reset    (reset),
      .enable   (bus.enable),
      .load     (tmr_load),
      .load_val (tmr_val),
      .hold     (bus.hold),
      .zero     (tmr_zero)
   );

   // Pulses (char_available, done) default low so a frozen cycle never repeats them.
   always_comb begin
      state_d  = state_q;
      char_d   = char_q;
      avail_d  = 1'b0;
      done_d   = 1'b0;
      index_d  = index_q;
      len_d    = len_q;
      mem_we   = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = '0;
      next_idx = index_q + 1'b1;
      if (bus.enable) begin
         unique case (state_q)
            S_IDLE: begin
               mem_we = bus.wr_en;
               if (bus.start && !bus.stop && bus.msg_len != '0) begin
                  state_d  = S_SHOW;
                  len_d    = (bus.msg_len > DEPTH_L) ? DEPTH_L : bus.msg_len;
                  index_d  = '0;
                  char_d   = mem_q[0];
                  avail_d  = 1'b1;
                  tmr_load = 1'b1;
                  tmr_val  = DWELL_LD;
               end
            end
            S_SHOW, S_GAP: begin
               if (bus.stop) begin
                  state_d  = S_IDLE;
                  char_d   = SEG_BLANK;
                  avail_d  = 1'b1;
                  tmr_load = 1'b1;
               end else if (tmr_zero && !bus.hold) begin
                  if (state_q == S_SHOW && GAP > 0) begin
                     state_d  = S_GAP;
                     char_d   = SEG_BLANK;
                     avail_d  = 1'b1;
                     tmr_load = 1'b1;
                     tmr_val  = GAP_LD;
                  end else if ({1'b0, index_q} + 1'b1 < len_q) begin
                     state_d  = S_SHOW;
                     index_d  = next_idx;
                     char_d   = mem_q[next_idx];
                     avail_d  = 1'b1;
                     tmr_load = 1'b1;
                     tmr_val  = DWELL_LD;
                  end else if (bus.loop) begin
                     state_d  = S_SHOW;
                     index_d  = '0;
                     char_d   = mem_q[0];
                     avail_d  = 1'b1;
                     tmr_load = 1'b1;
                     tmr_val  = DWELL_LD;
                  end else begin
                     state_d  = S_IDLE;
                     done_d   = 1'b1;
                     tmr_load = 1'b1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk60 or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         char_q  <= SEG_BLANK;
         avail_q <= 1'b0;
         done_q  <= 1'b0;
         index_q <= '0;
         len_q   <= '0;
         for (int i = 0; i < MSG_DEPTH; i++)
            mem_q[i] <= SEG_BLANK;
      end else begin
         state_q <= state_d;
         char_q  <= char_d;
         avail_q <= avail_d;
         done_q  <= done_d;
         index_q <= index_d;
         len_q   <= len_d;
         if (mem_we)
            mem_q[bus.wr_addr] <= bus.wr_data;
      end
   end

   assign bus.char_out       = char_q;
   assign bus.char_available = avail_q;
   assign bus.char_index     = index_q;
   assign bus.busy           = (state_q != S_IDLE);
   assign bus.done           = done_q;

endmodule

// File: tb/tb_segment_sequencer.sv
// tb/tb_segment_sequencer.sv - randomized directed bench for segment_sequencer against an event-timeline model
module tb_segment_sequencer;

   typedef struct packed {
      logic        dn;
      logic [6:0]  ch;
      logic [23:0] t;
   } ev_t;
   typedef ev_t evq_t[$];

   logic       clk60 = 1'b0;
   logic       reset = 1'b1;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         rec_lo = 1;
   int         rec_hi = 0;
   logic [6:0] mem_m [8];
   evq_t       qa, qb;

   segment_sequencer_if #(.MSG_DEPTH(8)) ifa ();
   segment_sequencer_if #(.MSG_DEPTH(8)) ifb ();

   assign ifb.enable  = ifa.enable;
   assign ifb.wr_en   = ifa.wr_en;
   assign ifb.wr_addr = ifa.wr_addr;
   assign ifb.wr_data = ifa.wr_data;
   assign ifb.msg_len = ifa.msg_len;
   assign ifb.start   = ifa.start;
   assign ifb.stop    = ifa.stop;
   assign ifb.loop    = ifa.loop;
   assign ifb.hold    = ifa.hold;

   segment_sequencer #(.MSG_DEPTH(8), .DWELL(4), .GAP(0)) u_a (
      .clk60 (clk60), .reset (reset), .bus (ifa)
   );
   segment_sequencer #(.MSG_DEPTH(8), .DWELL(3), .GAP(2)) u_b (
      .clk60 (clk60), .reset (reset), .bus (ifb)
   );

   always #5 clk60 = ~clk60;
   always @(posedge clk60) cyc <= cyc + 1;

   always @(negedge clk60) begin
      if (cyc >= rec_lo && cyc <= rec_hi) begin
         if (ifa.char_available) qa.push_back({1'b0, ifa.char_out, 24'(cyc)});
         if (ifa.done)           qa.push_back({1'b1, 7'h00, 24'(cyc)});
         if (ifb.char_available) qb.push_back({1'b0, ifb.char_out, 24'(cyc)});
         if (ifb.done)           qb.push_back({1'b1, 7'h00, 24'(cyc)});
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " A char_out"}, 32'(ifa.char_out), 0);
      chk({tag, " A avail"},    32'(ifa.char_available), 0);
      chk({tag, " A index"},    32'(ifa.char_index), 0);
      chk({tag, " A busy"},     32'(ifa.busy), 0);
      chk({tag, " A done"},     32'(ifa.done), 0);
      chk({tag, " B char_out"}, 32'(ifb.char_out), 0);
      chk({tag, " B avail"},    32'(ifb.char_available), 0);
      chk({tag, " B index"},    32'(ifb.char_index), 0);
      chk({tag, " B busy"},     32'(ifb.busy), 0);
      chk({tag, " B done"},     32'(ifb.done), 0);
   endtask

   task automatic wr(input int a, input logic [6:0] d);
      @(negedge clk60);
      ifa.wr_en = 1'b1; ifa.wr_addr = 3'(a); ifa.wr_data = d;
      mem_m[a] = d;
      @(negedge clk60);
      ifa.wr_en = 1'b0;
   endtask

   // Nominal edge -> real edge: every held or frozen edge pushes later events back by one.
   function automatic int map_t(input int t, input int c0, input int hs, input int hl,
                                input int fs, input int fl);
      int r;
      r = t;
      if (hl > 0 && r >= c0 + hs) r += hl;
      if (fl > 0 && r >= c0 + fs) r += fl;
      return r;
   endfunction

   task automatic check_run(input string tag, input int d, input int g, input int mlen,
                            input bit lp, input int c0, input int win, input int hs,
                            input int hl, input int fs, input int fl, input evq_t obs);
      evq_t exp_q;
      int   len, idx, t, r, n;
      len = (mlen > 8) ? 8 : mlen;
      t = c0;
      idx = 0;
      while (len > 0 && t <= c0 + win) begin
         r = map_t(t, c0, hs, hl, fs, fl);
         if (r < c0 + win) exp_q.push_back({1'b0, mem_m[idx], 24'(r)});
         if (g > 0) begin
            r = map_t(t + d, c0, hs, hl, fs, fl);
            if (r < c0 + win) exp_q.push_back({1'b0, 7'h00, 24'(r)});
         end
         t += d + g;
         idx++;
         if (idx == len) begin
            if (lp) idx = 0;
            else begin
               r = map_t(t, c0, hs, hl, fs, fl);
               if (r < c0 + win) exp_q.push_back({1'b1, 7'h00, 24'(r)});
               break;
            end
         end
      end
      chk({tag, " event count"}, obs.size(), exp_q.size());
      n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s event %0d", tag, i), obs[i], exp_q[i]);
   endtask

   task automatic run(input string tag, input int mlen, input bit lp, input int win,
                      input int hs, input int hl, input int fs, input int fl, input bit poke);
      int c0, e;
      qa.delete();
      qb.delete();
      @(negedge clk60);
      ifa.msg_len = 4'(mlen); ifa.loop = lp; ifa.start = 1'b1;
      c0 = cyc + 1;
      rec_lo = c0;
      rec_hi = c0 + win - 1;
      @(negedge clk60);
      ifa.start = 1'b0;
      for (int k = 0; k < win; k++) begin
         e = cyc + 1;
         ifa.hold   = (e >= c0 + hs && e < c0 + hs + hl);
         ifa.enable = !(e >= c0 + fs && e < c0 + fs + fl);
         if (poke && e == c0 + 2) begin
            ifa.wr_en = 1'b1; ifa.wr_addr = 3'd0; ifa.wr_data = ~mem_m[0];
            ifa.start = 1'b1; ifa.msg_len = 4'd1;
         end else begin
            ifa.wr_en = 1'b0; ifa.start = 1'b0; ifa.msg_len = 4'(mlen);
         end
         @(negedge clk60);
      end
      ifa.hold = 1'b0; ifa.enable = 1'b1; ifa.wr_en = 1'b0; ifa.start = 1'b0;
      check_run({tag, " A"}, 4, 0, mlen, lp, c0, win, hs, hl, fs, fl, qa);
      check_run({tag, " B"}, 3, 2, mlen, lp, c0, win, hs, hl, fs, fl, qb);
   endtask

   task automatic do_stop(input string tag);
      ifa.stop = 1'b1;
      @(negedge clk60);
      ifa.stop = 1'b0;
      chk({tag, " stop A avail"}, 32'(ifa.char_available), 1);
      chk({tag, " stop A char"},  32'(ifa.char_out), 0);
      chk({tag, " stop A busy"},  32'(ifa.busy), 0);
      chk({tag, " stop A done"},  32'(ifa.done), 0);
      chk({tag, " stop B avail"}, 32'(ifb.char_available), 1);
      chk({tag, " stop B char"},  32'(ifb.char_out), 0);
      chk({tag, " stop B busy"},  32'(ifb.busy), 0);
      chk({tag, " stop B done"},  32'(ifb.done), 0);
      @(negedge clk60);
      chk({tag, " after stop A done"}, 32'(ifa.done), 0);
      chk({tag, " after stop B done"}, 32'(ifb.done), 0);
   endtask

   initial begin
      int L, hs, hl, fs;
      bit found;
      ifa.enable = 1'b1; ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0;
      ifa.msg_len = '0; ifa.start = 1'b0; ifa.stop = 1'b0; ifa.loop = 1'b0; ifa.hold = 1'b0;
      for (int i = 0; i < 8; i++) mem_m[i] = 7'h00;
      repeat (2) @(negedge clk60);
      chk_zero("reset");
      reset = 1'b0;

      wr(0, 7'h06); wr(1, 7'h5B); wr(2, 7'h4F);
      run("oneshot", 3, 1'b0, 19, 0, 0, 0, 0, 1'b0);
      chk("oneshot A busy", 32'(ifa.busy), 0);
      chk("oneshot A last char", 32'(ifa.char_out), 32'h4F);
      chk("oneshot B busy", 32'(ifb.busy), 0);
      chk("oneshot B blank", 32'(ifb.char_out), 0);

      for (int i = 0; i < 8; i++) wr(i, 7'($urandom));
      L  = int'($urandom_range(1, 8));
      hs = int'($urandom_range(1, 6));
      run("loop+hold", L, 1'b1, 40, hs, 5, 0, 0, 1'b0);
      do_stop("loop");

      hs = int'($urandom_range(4, 8));
      hl = int'($urandom_range(1, 4));
      fs = hs + hl + int'($urandom_range(2, 10));
      run("busy-guard+freeze", 8, 1'b0, 60, hs, hl, fs, 10, 1'b1);

      run("len12", 12, 1'b0, 44, 0, 0, 0, 0, 1'b0);
      run("len0", 0, 1'b0, 8, 0, 0, 0, 0, 1'b0);
      chk("len0 A busy", 32'(ifa.busy), 0);
      chk("len0 B busy", 32'(ifb.busy), 0);

      wr(0, 7'($urandom) | 7'h01);
      wr(1, 7'($urandom) | 7'h01);
      @(negedge clk60);
      ifa.msg_len = 4'd2; ifa.loop = 1'b1; ifa.start = 1'b1;
      @(negedge clk60);
      ifa.start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (ifb.busy && ifb.char_out == 7'h00) found = 1'b1;
         else @(negedge clk60);
      end
      chk("B reached gap", 32'(found), 1);
      #2 reset = 1'b1;
      #1 chk_zero("async reset");
      @(negedge clk60);
      reset = 1'b0;
      ifa.loop = 1'b0;
      for (int i = 0; i < 8; i++) mem_m[i] = 7'h00;
      run("post-reset mem", 2, 1'b0, 14, 0, 0, 0, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
